mem_block_image_ctrl: RTL and testbench

Ping-pong sequencer for one `memBlockImage` instance: 8192 lines of 1024 bits, i.e. 16 complex samples per line.
- Splits the memory into two banks of 4096 lines.
- Fills one bank from an upstream valid/ready line stream while draining the other bank to a downstream valid/ready stream, one tile per bank.
- Hides the memory's 1-cycle registered read behind a credit-controlled output FIFO, so downstream backpressure never loses data.
- Sits between the image loader and the FFT/convolution engine.

---
 rtl/mem_block_image_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_block_image_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_image_ctrl.sv
// mem_block_image_ctrl
// Ping-pong sequencer for one memBlockImage (8192 x 1024-bit lines).
// Bank 0 (addr bit 12 = 0) and bank 1 alternate between fill and drain,
// one tile per bank. Reads are issued against free output FIFO slots, so
// the memory's registered read never needs to be stalled.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data  upstream line stream
//   out_valid/out_ready        downstream line stream (FIFO head)
//   out_data/out_last          head line and end-of-tile tag
//   mem_wr/mem_waddr/mem_wdata write port to memBlockImage
//   mem_re/mem_raddr/mem_rdata read port to memBlockImage (1-cycle latency)
//   bank_full                  per-bank full flags
//   tile_done                  pulse when the last line of a tile is popped
module mem_block_image_ctrl #(
    parameter int TILE_LINES = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] out_data,
    output logic          out_last,
    output logic          mem_wr,
    output logic [12:0]   mem_waddr,
    output logic [1023:0] mem_wdata,
    output logic          mem_re,
    output logic [12:0]   mem_raddr,
    input  logic [1023:0] mem_rdata,
    output logic [1:0]    bank_full,
    output logic          tile_done
);
    localparam int PW = (TILE_LINES > 1) ? $clog2(TILE_LINES) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(TILE_LINES - 1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic                                wr_bank_q, wr_bank_d;
    logic                                rd_bank_q, rd_bank_d;
    logic [PW-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                          bank_full_q, bank_full_d;
    logic                                p1_q, p1_d;
    logic                                p1_last_q, p1_last_d;
    logic [CW-1:0]                       fifo_cnt_q, fifo_cnt_d;
    logic [FW-1:0]                       fifo_head_q, fifo_head_d;
    logic [FW-1:0]                       fifo_tail_q, fifo_tail_d;
    logic [FIFO_DEPTH-1:0]               fifo_last_q, fifo_last_d;
    logic [FIFO_DEPTH-1:0][1023:0]       fifo_data_q, fifo_data_d;

    logic        credit_ok, wr_end, rd_end, push, pop;
    logic [11:0] wr_line, rd_line;

    function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
        return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // In-bank line offset; bits above the tile size stay zero.
        wr_line           = '0;
        wr_line[PW-1:0]   = wr_ptr_q;
        rd_line           = '0;
        rd_line[PW-1:0]   = rd_ptr_q;

        in_ready  = ~(&bank_full_q);
        mem_wr    = in_valid & in_ready & ~reset;
        mem_waddr = {wr_bank_q, wr_line};
        mem_wdata = in_data;

        // Every line already in the FIFO or still in the read pipe holds a
        // slot, so a push can never find the FIFO full.
        credit_ok = ({1'b0, fifo_cnt_q} + {{CW{1'b0}}, p1_q}) < DEPTH_C;
        mem_re    = (|bank_full_q) & credit_ok;
        mem_raddr = {rd_bank_q, rd_line};

        wr_end = mem_wr & (wr_ptr_q == PTR_MAX);
        rd_end = mem_re & (rd_ptr_q == PTR_MAX);

        out_valid = (fifo_cnt_q != '0);
        out_data  = out_valid ? fifo_data_q[fifo_head_q] : '0;
        out_last  = out_valid & fifo_last_q[fifo_head_q];
        pop       = out_valid & out_ready;
        // mem_rdata is valid the cycle after issue, which is when p1 is set.
        push      = p1_q;
        tile_done = pop & out_last;
        bank_full = bank_full_q;

        wr_ptr_d  = mem_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        wr_bank_d = wr_bank_q ^ wr_end;
        rd_ptr_d  = mem_re ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_bank_d = rd_bank_q ^ rd_end;

        // The bank being written is never full and the bank being read is
        // always full, so set and clear never target the same bit.
        bank_full_d = bank_full_q;
        if (wr_end) bank_full_d[wr_bank_q] = 1'b1;
        if (rd_end) bank_full_d[rd_bank_q] = 1'b0;

        p1_d      = mem_re;
        p1_last_d = rd_end;

        fifo_tail_d = push ? fifo_inc(fifo_tail_q) : fifo_tail_q;
        fifo_head_d = pop  ? fifo_inc(fifo_head_q) : fifo_head_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        if (push) begin
            fifo_data_d[fifo_tail_q] = mem_rdata;
            fifo_last_d[fifo_tail_q] = p1_last_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bank_full_q <= '0;
            p1_q        <= 1'b0;
            p1_last_q   <= 1'b0;
            fifo_cnt_q  <= '0;
            fifo_head_q <= '0;
            fifo_tail_q <= '0;
            fifo_last_q <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            p1_q        <= p1_d;
            p1_last_q   <= p1_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_head_q <= fifo_head_d;
            fifo_tail_q <= fifo_tail_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    // Line storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
    end
endmodule

// File: tb/tb_mem_block_image_ctrl.sv
module tb_mem_block_image_ctrl;
    localparam int T = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [1023:0] in_data = '0, mem_rdata = '0;
    logic          in_ready, out_valid, out_last, mem_wr, mem_re, tile_done;
    logic [1023:0] out_data, mem_wdata;
    logic [12:0]   mem_waddr, mem_raddr;
    logic [1:0]    bank_full;

    always #5 clk = ~clk;

    mem_block_image_ctrl #(.TILE_LINES(T), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .bank_full(bank_full), .tile_done(tile_done)
    );

    // memBlockImage model: registered read, write at end of cycle.
    logic [1023:0] mem [0:8191];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (mem_wr) mem[mem_waddr] <= mem_wdata;
    end

    int cmp = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: stream counts and an ordered queue of accepted lines.
    int acc_n, iss_n, pop_n, ir_low, last_acc_cyc, first_ov_cyc, first_pop_cyc, last_pop_cyc;
    logic [1023:0] exp_q[$];
    bit hold_v, saw_swap;
    logic [1023:0] hold_d;
    logic [1:0] prev_bf;

    task automatic clear_model();
        acc_n = 0; iss_n = 0; pop_n = 0; exp_q.delete(); hold_v = 0;
        saw_swap = 0; prev_bf = 2'b00; first_ov_cyc = -1; first_pop_cyc = -1;
    endtask

    always @(negedge clk) begin : mon
        int tf;
        logic [1:0] ebf;
        logic [12:0] ea;
        logic [1023:0] e;
        bit elast;
        if (!reset) begin
            tf  = acc_n / T - iss_n / T;
            ebf = 2'b00;
            for (int k = iss_n / T; k < acc_n / T; k++) ebf[k % 2] = 1'b1;
            cmp++; if (in_ready !== (tf < 2)) begin bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, tf < 2); end
            cmp++; if (bank_full !== ebf) begin bad++; $display("FAIL bank_full cyc=%0d got=%b exp=%b", cyc, bank_full, ebf); end
            cmp++; if (mem_wr !== (in_valid && tf < 2)) begin bad++; $display("FAIL mem_wr cyc=%0d got=%b", cyc, mem_wr); end
            if (!in_ready) ir_low++;
            if (prev_bf == 2'b01 && bank_full == 2'b10) saw_swap = 1;
            prev_bf = bank_full;
            if (mem_wr) begin
                ea = 13'(((acc_n / T) % 2) * 4096 + acc_n % T);
                cmp++; if (mem_waddr !== ea) begin bad++; $display("FAIL waddr got=%h exp=%h", mem_waddr, ea); end
                cmp++; if (mem_wdata !== in_data) begin bad++; $display("FAIL wdata got=%h exp=%h", mem_wdata[63:0], in_data[63:0]); end
                exp_q.push_back(in_data);
                last_acc_cyc = cyc;
                acc_n++;
            end
            if (mem_re) begin
                ea = 13'(((iss_n / T) % 2) * 4096 + iss_n % T);
                cmp++; if (tf <= 0) begin bad++; $display("FAIL read_no_full_bank cyc=%0d got=mem_re exp=idle", cyc); end
                cmp++; if (mem_raddr !== ea) begin bad++; $display("FAIL raddr got=%h exp=%h", mem_raddr, ea); end
                iss_n++;
            end
            cmp++; if (iss_n - pop_n > D) begin bad++; $display("FAIL credit outstanding=%0d max=%0d", iss_n - pop_n, D); end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (hold_v) begin
                cmp++; if (!out_valid || out_data !== hold_d) begin bad++; $display("FAIL hold got=%b/%h exp=1/%h", out_valid, out_data[63:0], hold_d[63:0]); end
            end
            if (out_valid && out_ready) begin
                elast = (pop_n % T == T - 1);
                cmp++;
                if (exp_q.size() == 0 || pop_n >= (acc_n / T) * T) begin
                    bad++; $display("FAIL spurious_pop cyc=%0d got=%h exp=none", cyc, out_data[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin bad++; $display("FAIL out_data n=%0d got=%h exp=%h", pop_n, out_data[63:0], e[63:0]); end
                end
                cmp++; if (out_last !== elast) begin bad++; $display("FAIL out_last n=%0d got=%b exp=%b", pop_n, out_last, elast); end
                cmp++; if (tile_done !== elast) begin bad++; $display("FAIL tile_done n=%0d got=%b exp=%b", pop_n, tile_done, elast); end
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_n++;
            end else begin
                cmp++; if (tile_done !== 1'b0) begin bad++; $display("FAIL tile_done_idle cyc=%0d got=%b exp=0", cyc, tile_done); end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    function automatic logic [1023:0] rnd_line();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Sends n lines; vpct = percent of cycles with in_valid high.
    task automatic send_lines(input int n, input int vpct, input bit rnd, input int base);
        int sent = 0, guard = 0;
        bit acc;
        logic [1023:0] d;
        d = rnd ? rnd_line() : 1024'(base);
        while (sent < n && guard < 2000) begin
            in_data  = d;
            in_valid = ($urandom_range(99) < vpct);
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                d = rnd ? rnd_line() : 1024'(base + sent);
            end
            guard++;
        end
        in_valid = 1'b0;
        cmp++; if (sent != n) begin bad++; $display("FAIL send_timeout got=%0d exp=%0d", sent, n); end
    endtask

    task automatic drain();
        int g = 0;
        out_ready = 1'b1;
        while (pop_n < (acc_n / T) * T && g < 500) begin @(posedge clk); #1; g++; end
        repeat (3) begin @(posedge clk); #1; end
        cmp++; if (pop_n != (acc_n / T) * T) begin bad++; $display("FAIL drain got=%0d exp=%0d", pop_n, (acc_n / T) * T); end
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        clear_model();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = rnd_line();
        #2;
        cmp++; if ({in_ready, out_valid, out_last, mem_wr, mem_re, bank_full, tile_done} !== 8'b1000_0000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=10000000", {in_ready, out_valid, out_last, mem_wr, mem_re, bank_full, tile_done}); end
        cmp++; if ({mem_waddr, mem_raddr} !== 26'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", {mem_waddr, mem_raddr}); end
        cmp++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data[63:0]); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear_model();
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        cmp++; if ({in_ready, out_valid, bank_full} !== 4'b1000) begin bad++; $display("FAIL idle got=%b exp=1000", {in_ready, out_valid, bank_full}); end
    endtask

    task automatic test_single_tile();
        apply_reset();
        out_ready = 1'b1;
        send_lines(T, 100, 1'b0, 0);
        drain();
        cmp++; if (first_ov_cyc - last_acc_cyc != 3) begin bad++; $display("FAIL latency got=%0d exp=3", first_ov_cyc - last_acc_cyc); end
        cmp++; if (pop_n != T) begin bad++; $display("FAIL single_count got=%0d exp=%0d", pop_n, T); end
    endtask

    task automatic test_stream();
        apply_reset();
        out_ready = 1'b1; ir_low = 0;
        send_lines(4 * T, 100, 1'b1, 0);
        drain();
        cmp++; if (ir_low != 0) begin bad++; $display("FAIL stream_in_ready got=%0d low cycles exp=0", ir_low); end
        cmp++; if (last_pop_cyc - first_pop_cyc != 4 * T - 1) begin bad++; $display("FAIL stream_rate got=%0d exp=%0d", last_pop_cyc - first_pop_cyc, 4 * T - 1); end
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready = 1'b1;
        fork
            send_lines(3 * T, 100, 1'b1, 0);
            begin
                repeat (12) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (19) @(posedge clk);
                @(negedge clk);
                cmp++; if (mem_re !== 1'b0) begin bad++; $display("FAIL stall_mem_re got=%b exp=0", mem_re); end
                cmp++; if (iss_n - pop_n != D) begin bad++; $display("FAIL stall_buffered got=%0d exp=%0d", iss_n - pop_n, D); end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_both_full();
        apply_reset();
        out_ready = 1'b0;
        send_lines(2 * T, 100, 1'b1, 0);
        @(negedge clk);
        cmp++; if (bank_full !== 2'b11) begin bad++; $display("FAIL both_full got=%b exp=11", bank_full); end
        cmp++; if (in_ready !== 1'b0) begin bad++; $display("FAIL both_full_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        fork
            send_lines(T, 100, 1'b1, 0);
            begin repeat (5) @(posedge clk); #1 out_ready = 1'b1; end
        join
        drain();
    endtask

    task automatic test_same_cycle();
        apply_reset();
        out_ready = 1'b1;
        send_lines(2 * T, 100, 1'b1, 0);
        drain();
        cmp++; if (!saw_swap) begin bad++; $display("FAIL swap got=no_01_to_10 exp=01_to_10"); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        send_lines(T + 3, 100, 1'b1, 0);
        in_valid = 1'b1; in_data = rnd_line();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        cmp++; if ({in_ready, out_valid, out_last, mem_wr, mem_re, bank_full, tile_done} !== 8'b1000_0000) begin
            bad++; $display("FAIL midreset_ctl got=%b exp=10000000", {in_ready, out_valid, out_last, mem_wr, mem_re, bank_full, tile_done}); end
        cmp++; if ({mem_waddr, mem_raddr} !== 26'd0) begin bad++; $display("FAIL midreset_addr got=%h exp=0", {mem_waddr, mem_raddr}); end
        cmp++; if (out_data !== '0) begin bad++; $display("FAIL midreset_data got=%h exp=0", out_data[63:0]); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear_model();
        reset = 1'b0;
        send_lines(T, 100, 1'b1, 0);
        drain();
        cmp++; if (pop_n != T) begin bad++; $display("FAIL midreset_count got=%0d exp=%0d", pop_n, T); end
    endtask

    task automatic test_random();
        bit done = 0;
        apply_reset();
        fork
            begin send_lines(6 * T, 60, 1'b1, 0); done = 1; end
            begin
                for (int i = 0; i < 2000 && !done; i++) begin @(posedge clk); #1 out_ready = $urandom_range(1); end
                out_ready = 1'b1;
            end
        join
        drain();
        cmp++; if (pop_n != 6 * T) begin bad++; $display("FAIL random_count got=%0d exp=%0d", pop_n, 6 * T); end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_single_tile();
        test_stream();
        test_stall();
        test_both_full();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
